// File: rtl/mandelbrot_cfg_sequencer_pkg.sv
// Shared constants, preset table and FSM state type for the tinymandelbrot
// serial configuration master.
package mandelbrot_cfg_pkg;

  localparam int unsigned CFG_W_DEF = 33;
  localparam int unsigned PRESET_N  = 8;

  localparam logic [32:0] PRESET [PRESET_N] = '{
    33'h03CF10404, 33'h07DF10404, 33'h0FEF10404, 33'h1FFF10404,
    33'h03CF10404, 33'h07CF10404, 33'h0FCF10404, 33'h1FCF10404
  };

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETUP,
    ST_HIGH,
    ST_LOW,
    ST_TRAIL
  } cfg_state_e;

  function automatic logic [32:0] preset_word(input logic [2:0] idx);
    return PRESET[idx];
  endfunction

endpackage

// File: rtl/mandelbrot_cfg_sequencer_shifter.sv
// Shift register, sclk half-period divider and bit counter for one config
// frame; sequenced entirely by the controlling FSM.
module cfg_shifter
  import mandelbrot_cfg_pkg::*;
#(
  parameter int unsigned CFG_W    = CFG_W_DEF,
  parameter int unsigned SCLK_DIV = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CFG_W-1:0] word,
  input  logic             run,
  input  logic             shift,
  input  logic             advance,
  output logic             sdata,
  output logic             half_done,
  output logic             last_bit
);

  localparam int unsigned DIV_W = $clog2(SCLK_DIV + 1);

  logic [DIV_W-1:0] div_cnt;
  logic [5:0]       bit_ctr;
  logic [CFG_W-1:0] sr;

  assign half_done = run && (div_cnt == DIV_W'(SCLK_DIV - 1));
  assign last_bit  = (bit_ctr == 6'(CFG_W - 1));
  assign sdata     = sr[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      bit_ctr <= '0;
      sr      <= '0;
    end else begin
      if (!run || half_done) div_cnt <= '0;
      else                   div_cnt <= div_cnt + DIV_W'(1);

      if (load) begin
        sr      <= word;
        bit_ctr <= '0;
      end else begin
        if (shift)   sr      <= {1'b0, sr[CFG_W-1:1]};
        if (advance) bit_ctr <= bit_ctr + 6'd1;
      end
    end
  end

endmodule

// File: rtl/mandelbrot_cfg_sequencer.sv
// Serial config master: sends either a host word or the next preset over the
// cfg_en/cfg_sclk/cfg_sdata port, LSB first. Host word wins over a preset request.
module mandelbrot_cfg_sequencer
  import mandelbrot_cfg_pkg::*;
#(
  parameter int unsigned CFG_W    = CFG_W_DEF,
  parameter int unsigned SCLK_DIV = 1,
  parameter int unsigned N_PRESET = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        next_i,
  input  logic                        cfg_valid,
  input  logic [CFG_W-1:0]            cfg_data,
  output logic                        cfg_ready,
  output logic                        cfg_en,
  output logic                        cfg_sclk,
  output logic                        cfg_sdata,
  output logic                        busy,
  output logic                        done,
  output logic [$clog2(N_PRESET)-1:0] preset_idx
);

  localparam int unsigned IDX_W = $clog2(N_PRESET);

  cfg_state_e       state;
  logic             next_q;
  logic             is_preset;
  logic [CFG_W-1:0] word_q;
  logic             next_edge;
  logic             half_done;
  logic             last_bit;
  logic             sh_load;
  logic             sh_run;
  logic             sh_shift;
  logic             sh_adv;

  assign next_edge = next_i & ~next_q;
  assign cfg_ready = (state == ST_IDLE);

  // The word shifts as sclk falls, so sdata only moves while sclk is low
  // and stays stable across every high phase.
  assign sh_load  = (state == ST_LOAD);
  assign sh_run   = state inside {ST_SETUP, ST_HIGH, ST_LOW};
  assign sh_shift = (state == ST_HIGH) && half_done;
  assign sh_adv   = (state == ST_LOW) && half_done && !last_bit;

  cfg_shifter #(
    .CFG_W    (CFG_W),
    .SCLK_DIV (SCLK_DIV)
  ) u_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (sh_load),
    .word      (word_q),
    .run       (sh_run),
    .shift     (sh_shift),
    .advance   (sh_adv),
    .sdata     (cfg_sdata),
    .half_done (half_done),
    .last_bit  (last_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      next_q     <= 1'b1;
      is_preset  <= 1'b0;
      word_q     <= '0;
      cfg_en     <= 1'b0;
      cfg_sclk   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      preset_idx <= '0;
    end else begin
      next_q <= next_i;
      done   <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (cfg_valid) begin
            word_q    <= cfg_data;
            is_preset <= 1'b0;
            busy      <= 1'b1;
            state     <= ST_LOAD;
          end else if (next_edge) begin
            word_q    <= CFG_W'(preset_word(3'(preset_idx)));
            is_preset <= 1'b1;
            busy      <= 1'b1;
            state     <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          cfg_en <= 1'b1;
          state  <= ST_SETUP;
        end
        ST_SETUP: begin
          if (half_done) begin
            cfg_sclk <= 1'b1;
            state    <= ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (half_done) begin
            cfg_sclk <= 1'b0;
            state    <= ST_LOW;
          end
        end
        ST_LOW: begin
          if (half_done) begin
            if (last_bit) begin
              cfg_en <= 1'b0;
              state  <= ST_TRAIL;
            end else begin
              cfg_sclk <= 1'b1;
              state    <= ST_HIGH;
            end
          end
        end
        ST_TRAIL: begin
          if (is_preset) preset_idx <= preset_idx + IDX_W'(1);
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mandelbrot_cfg_sequencer.sv
// Directed bench for mandelbrot_cfg_sequencer: default divider instance plus a
// SCLK_DIV=3 instance, with frame reassembly and timing checks.
module tb_mandelbrot_cfg_sequencer;

  logic        clk;
  logic        rst_n;
  logic        next_i, cfg_valid;
  logic [32:0] cfg_data;
  logic        cfg_ready, cfg_en, cfg_sclk, cfg_sdata, busy, done;
  logic [2:0]  preset_idx;

  logic        next3, valid3;
  logic [32:0] data3;
  logic        ready3, en3, sclk3, sdata3, busy3, done3;
  logic [2:0]  idx3;

  bit   use3;
  logic m_busy, m_sclk, m_sdata, m_done, m_en, m_ready;

  int total = 0;
  int bad   = 0;

  logic [32:0] PEXP [8];

  mandelbrot_cfg_sequencer dut (
    .clk(clk), .rst_n(rst_n), .next_i(next_i), .cfg_valid(cfg_valid),
    .cfg_data(cfg_data), .cfg_ready(cfg_ready), .cfg_en(cfg_en),
    .cfg_sclk(cfg_sclk), .cfg_sdata(cfg_sdata), .busy(busy), .done(done),
    .preset_idx(preset_idx)
  );

  mandelbrot_cfg_sequencer #(.SCLK_DIV(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .next_i(next3), .cfg_valid(valid3),
    .cfg_data(data3), .cfg_ready(ready3), .cfg_en(en3),
    .cfg_sclk(sclk3), .cfg_sdata(sdata3), .busy(busy3), .done(done3),
    .preset_idx(idx3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    m_busy  = use3 ? busy3  : busy;
    m_sclk  = use3 ? sclk3  : cfg_sclk;
    m_sdata = use3 ? sdata3 : cfg_sdata;
    m_done  = use3 ? done3  : done;
    m_en    = use3 ? en3    : cfg_en;
    m_ready = use3 ? ready3 : cfg_ready;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Follows one frame from LOAD to the done cycle; optionally injects a next
  // edge plus host valid mid-frame (inject_at = busy cycle number, -1 = none).
  task automatic xfer(input string tag, input int div, input int exp_busy,
                      input logic [32:0] exp_word, input int inject_at);
    int cyc = 0, rises = 0, chg = 0, en_bad = 0, run_bad = 0;
    int early_done = 0, hi_run = 0, lo_run = 0, hi_total = 0;
    logic prev_sclk = 1'b0;
    logic prev_sdata;
    logic [32:0] got = '0;
    bit started = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (m_busy) begin
        started = 1'b1;
        break;
      end
    end
    chk({tag, "_start"}, 64'(started), 64'(1));
    if (!started) return;
    prev_sdata = m_sdata;
    while (m_busy && cyc < 1000) begin
      cyc++;
      if (m_done) early_done++;
      if (m_sclk) begin
        if (!prev_sclk) begin
          if (rises > 0 && lo_run != div) run_bad++;
          if (rises < 33) got[rises] = m_sdata;
          rises++;
          hi_run = 0;
        end
        hi_run++;
        hi_total++;
        if (!m_en) en_bad++;
        if (m_sdata !== prev_sdata) chg++;
      end else begin
        if (prev_sclk) begin
          if (hi_run != div) run_bad++;
          lo_run = 0;
        end
        lo_run++;
      end
      if (inject_at >= 0 && cyc == inject_at) begin
        chk({tag, "_ready_busy"}, 64'(m_ready), 64'(0));
        next_i    = 1'b0;
        cfg_valid = 1'b1;
        cfg_data  = 33'h0AAAA5555;
      end
      if (inject_at >= 0 && cyc == inject_at + 1) begin
        next_i    = 1'b1;
        cfg_valid = 1'b0;
      end
      prev_sclk  = m_sclk;
      prev_sdata = m_sdata;
      @(negedge clk);
    end
    chk({tag, "_busy_cycles"}, 64'(cyc), 64'(exp_busy));
    chk({tag, "_sclk_rises"}, 64'(rises), 64'(33));
    chk({tag, "_word"}, 64'(got), 64'(exp_word));
    chk({tag, "_sclk_high_total"}, 64'(hi_total), 64'(33 * div));
    chk({tag, "_half_period"}, 64'(run_bad), 64'(0));
    chk({tag, "_sdata_while_high"}, 64'(chg), 64'(0));
    chk({tag, "_en_during_sclk"}, 64'(en_bad), 64'(0));
    chk({tag, "_done_early"}, 64'(early_done), 64'(0));
    chk({tag, "_done_pulse"}, 64'(m_done), 64'(1));
    @(negedge clk);
    chk({tag, "_done_drop"}, 64'(m_done), 64'(0));
  endtask

  initial begin
    int cnt;
    int rises;
    logic prev;
    PEXP = '{33'h03CF10404, 33'h07DF10404, 33'h0FEF10404, 33'h1FFF10404,
             33'h03CF10404, 33'h07CF10404, 33'h0FCF10404, 33'h1FCF10404};
    use3      = 1'b0;
    rst_n     = 1'b0;
    next_i    = 1'b1;
    cfg_valid = 1'b0;
    cfg_data  = '0;
    next3     = 1'b0;
    valid3    = 1'b0;
    data3     = '0;

    // reset state, with next_i held high throughout
    repeat (3) @(negedge clk);
    chk("rst_en", 64'(cfg_en), 64'(0));
    chk("rst_sclk", 64'(cfg_sclk), 64'(0));
    chk("rst_sdata", 64'(cfg_sdata), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_idx", 64'(preset_idx), 64'(0));
    chk("rst_ready", 64'(cfg_ready), 64'(1));
    rst_n = 1'b1;
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy) cnt++;
    end
    chk("held_button_no_xfer", 64'(cnt), 64'(0));

    // test 1: first preset
    next_i = 1'b0;
    @(negedge clk);
    next_i = 1'b1;
    xfer("p0", 1, 69, 33'h03CF10404, -1);
    chk("p0_idx", 64'(preset_idx), 64'(1));

    // test 2: eight more edges, wrapping through the table
    for (int k = 1; k <= 8; k++) begin
      next_i = 1'b0;
      @(negedge clk);
      next_i = 1'b1;
      xfer($sformatf("p%0d", k), 1, 69, PEXP[k % 8], -1);
      chk($sformatf("p%0d_idx", k), 64'(preset_idx), 64'((k + 1) % 8));
    end

    // test 3: host word and next edge in the same IDLE cycle
    next_i = 1'b0;
    @(negedge clk);
    chk("host_ready", 64'(cfg_ready), 64'(1));
    next_i    = 1'b1;
    cfg_valid = 1'b1;
    cfg_data  = 33'h123456789;
    @(posedge clk);
    #1 cfg_valid = 1'b0;
    xfer("host", 1, 69, 33'h123456789, -1);
    chk("host_idx", 64'(preset_idx), 64'(1));
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy) cnt++;
    end
    chk("host_edge_lost", 64'(cnt), 64'(0));

    // test 4: edge and host valid while busy are dropped
    next_i = 1'b0;
    @(negedge clk);
    next_i = 1'b1;
    xfer("drop", 1, 69, 33'h07DF10404, 20);
    chk("drop_idx", 64'(preset_idx), 64'(2));
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy || done) cnt++;
    end
    chk("drop_no_followup", 64'(cnt), 64'(0));

    // test 5: reset during bit 17
    next_i = 1'b0;
    @(negedge clk);
    next_i = 1'b1;
    rises = 0;
    prev  = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cfg_sclk && !prev) rises++;
      prev = cfg_sclk;
      if (rises == 18) break;
    end
    chk("abort_reached_bit17", 64'(rises), 64'(18));
    rst_n = 1'b0;
    #1;
    chk("abort_en", 64'(cfg_en), 64'(0));
    chk("abort_sclk", 64'(cfg_sclk), 64'(0));
    chk("abort_sdata", 64'(cfg_sdata), 64'(0));
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_idx", 64'(preset_idx), 64'(0));
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) cnt++;
    end
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (done || busy) cnt++;
    end
    chk("abort_no_done", 64'(cnt), 64'(0));
    chk("abort_idx_after", 64'(preset_idx), 64'(0));

    // test 6: SCLK_DIV=3 instance
    use3  = 1'b1;
    next3 = 1'b1;
    xfer("div3", 3, 203, 33'h03CF10404, -1);
    chk("div3_idx", 64'(idx3), 64'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
